// File: rtl/ifstage_hs.sv
// Instruction-fetch stage with a request/ack handshake to instruction memory.
//
// Fetches the word at PC, registers it into Instr and waits in VALID until
// control advances the PC. The next PC is PC+4, or PC+4+PC_Immed for a taken
// branch. A FETCH that sees no ack for TIMEOUT cycles pulses Fetch_Err and
// keeps re-issuing the same request.
//
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-low reset
//   PC_sel, PC_Immed    next-PC select (0: PC+4, 1: PC+4+PC_Immed) and offset
//   PC_LdEn             advance request, honoured only in VALID
//   IMEM_Req/Addr       memory request and word-aligned fetch address
//   IMEM_Ack/Data       memory response strobe and data (same cycle)
//   Instr, Instr_Valid  registered instruction and its qualifier
//   PC                  current PC
//   Busy                low only in VALID
//   Misalign            sticky: a computed next PC had nonzero [1:0]
//   Fetch_Err           one-cycle pulse on fetch timeout
module ifstage_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PC_sel,
  input  logic [31:0] PC_Immed,
  input  logic        PC_LdEn,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Ack,
  input  logic [31:0] IMEM_Data,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic [31:0] PC,
  output logic        Busy,
  output logic        Misalign,
  output logic        Fetch_Err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter holds the number of ack-less cycles already seen, so the
  // cycle in which it equals TIMEOUT-1 is the TIMEOUT-th one.
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  logic            fetch_err_q, fetch_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     next_pc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    misalign_d  = misalign_q;
    fetch_err_d = 1'b0;
    cnt_d       = cnt_q;
    // Modulo-2^32 arithmetic; the carry out is simply dropped.
    next_pc     = pc_q + 32'd4 + (PC_sel ? PC_Immed : 32'd0);

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        cnt_d   = '0;
      end
      StFetch: begin
        // Ack beats timeout when both land in the same cycle.
        if (IMEM_Ack) begin
          instr_d = IMEM_Data;
          valid_d = 1'b1;
          state_d = StValid;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          fetch_err_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StValid: begin
        if (PC_LdEn) begin
          pc_d    = {next_pc[31:2], 2'b00};
          valid_d = 1'b0;
          state_d = StFetch;
          cnt_d   = '0;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Request is decoded straight from state so the async reset drops it at once.
  assign IMEM_Req    = (state_q == StFetch);
  assign IMEM_Addr   = {pc_q[31:2], 2'b00};
  assign Instr       = instr_q;
  assign Instr_Valid = valid_q;
  assign PC          = pc_q;
  assign Busy        = (state_q != StValid);
  assign Misalign    = misalign_q;
  assign Fetch_Err   = fetch_err_q;

endmodule

// File: tb/tb_ifstage_hs.sv
module tb_ifstage_hs;

  logic        Clk;
  logic        Reset;
  logic        PC_sel;
  logic [31:0] PC_Immed;
  logic        PC_LdEn;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ack;
  logic [31:0] IMEM_Data;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic [31:0] PC;
  logic        Busy;
  logic        Misalign;
  logic        Fetch_Err;

  ifstage_hs #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (15)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PC_sel     (PC_sel),
    .PC_Immed   (PC_Immed),
    .PC_LdEn    (PC_LdEn),
    .IMEM_Req   (IMEM_Req),
    .IMEM_Addr  (IMEM_Addr),
    .IMEM_Ack   (IMEM_Ack),
    .IMEM_Data  (IMEM_Data),
    .Instr      (Instr),
    .Instr_Valid(Instr_Valid),
    .PC         (PC),
    .Busy       (Busy),
    .Misalign   (Misalign),
    .Fetch_Err  (Fetch_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: each new instruction (rising Instr_Valid) is checked against the
  // oldest expected fetch.
  initial begin : monitor
    logic iv_prev;
    exp_t e;
    iv_prev = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      if (Instr_Valid && !iv_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mon_unexpected: got instr 0x%08h pc 0x%08h expected none", Instr, PC);
        end else begin
          e = exp_q.pop_front();
          check("mon_instr", Instr, e.instr);
          check("mon_pc", PC, e.pc);
        end
      end
      iv_prev = Instr_Valid;
    end
  end

  // Called in the first FETCH cycle: waits, then acks with data.
  task automatic fetch_ack(input int waits, input logic [31:0] data, input logic [31:0] exp_pc);
    exp_t e;
    check("fetch_req", {31'b0, IMEM_Req}, 32'd1);
    check("fetch_addr", IMEM_Addr, exp_pc);
    for (int i = 0; i < waits; i++) tick();
    e.instr = data;
    e.pc    = exp_pc;
    exp_q.push_back(e);
    IMEM_Ack  = 1'b1;
    IMEM_Data = data;
    tick();
    IMEM_Ack  = 1'b0;
    IMEM_Data = 32'h0;
    check("valid_busy", {31'b0, Busy}, 32'd0);
  endtask

  // Called in VALID: pulses PC_LdEn and checks the resulting FETCH cycle.
  task automatic advance(input logic sel, input logic [31:0] immed,
                         input logic [31:0] exp_pc, input logic exp_mis);
    PC_LdEn  = 1'b1;
    PC_sel   = sel;
    PC_Immed = immed;
    tick();
    PC_LdEn  = 1'b0;
    PC_sel   = 1'b0;
    PC_Immed = 32'h0;
    check("adv_pc", PC, exp_pc);
    check("adv_valid", {31'b0, Instr_Valid}, 32'd0);
    check("adv_req", {31'b0, IMEM_Req}, 32'd1);
    check("adv_misalign", {31'b0, Misalign}, {31'b0, exp_mis});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    Reset     = 1'b0;
    PC_sel    = 1'b0;
    PC_Immed  = 32'h0;
    PC_LdEn   = 1'b0;
    IMEM_Ack  = 1'b0;
    IMEM_Data = 32'h0;

    #12;
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, 32'h0);
    check("rst_valid", {31'b0, Instr_Valid}, 32'd0);
    check("rst_req", {31'b0, IMEM_Req}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd1);
    check("rst_flags", {30'b0, Misalign, Fetch_Err}, 32'd0);

    // Release away from an edge; first edge goes IDLE -> FETCH.
    @(posedge Clk); #1;
    Reset = 1'b1;
    tick();
    fetch_ack(2, 32'h1234_5678, 32'h0);

    advance(1'b1, 32'h0000_000C, 32'h10, 1'b0);
    fetch_ack(1, 32'hA0A0_0001, 32'h10);
    advance(1'b0, 32'h0, 32'h14, 1'b0);
    check("seq_addr", IMEM_Addr, 32'h14);

    // PC_LdEn held during FETCH is ignored.
    PC_LdEn = 1'b1;
    PC_sel  = 1'b1;
    PC_Immed = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ldfetch_pc", PC, 32'h14);
    end
    PC_LdEn = 1'b0;
    PC_sel  = 1'b0;
    PC_Immed = 32'h0;
    fetch_ack(0, 32'hA0A0_0002, 32'h14);

    advance(1'b1, 32'h0000_00E8, 32'h100, 1'b0);
    fetch_ack(0, 32'hA0A0_0003, 32'h100);
    advance(1'b1, 32'hFFFF_FFF0, 32'hF4, 1'b0);
    fetch_ack(0, 32'hA0A0_0004, 32'hF4);
    advance(1'b1, 32'hFFFF_FF04, 32'hFFFF_FFFC, 1'b0);
    fetch_ack(0, 32'hA0A0_0005, 32'hFFFF_FFFC);
    advance(1'b0, 32'h0, 32'h0, 1'b0);
    fetch_ack(0, 32'hA0A0_0006, 32'h0);

    // Ack outside FETCH is ignored.
    IMEM_Ack  = 1'b1;
    IMEM_Data = 32'hDEAD_BEEF;
    tick();
    tick();
    IMEM_Ack  = 1'b0;
    IMEM_Data = 32'h0;
    check("stray_instr", Instr, 32'hA0A0_0006);
    check("stray_valid", {31'b0, Instr_Valid}, 32'd1);
    check("stray_pc", PC, 32'h0);

    // Timeout: 15 ack-less FETCH cycles -> one Fetch_Err pulse.
    advance(1'b0, 32'h0, 32'h4, 1'b0);
    for (int i = 0; i < 15; i++) begin
      check("to_no_err", {31'b0, Fetch_Err}, 32'd0);
      tick();
    end
    check("to_err", {31'b0, Fetch_Err}, 32'd1);
    check("to_req", {31'b0, IMEM_Req}, 32'd1);
    check("to_addr", IMEM_Addr, 32'h4);
    tick();
    check("to_pulse_end", {31'b0, Fetch_Err}, 32'd0);
    fetch_ack(0, 32'hB0B0_0001, 32'h4);

    // Ack on the 15th cycle wins over the timeout.
    advance(1'b0, 32'h0, 32'h8, 1'b0);
    fetch_ack(14, 32'hB0B0_0002, 32'h8);
    check("to_ack_wins", {31'b0, Fetch_Err}, 32'd0);

    // Misaligned target: low bits forced to 00, sticky flag.
    advance(1'b1, 32'h0000_0002, 32'hC, 1'b1);
    fetch_ack(0, 32'hC0C0_0001, 32'hC);
    advance(1'b0, 32'h0, 32'h10, 1'b1);

    // Async reset mid-FETCH, no clock edge in between.
    #2;
    Reset = 1'b0;
    #1;
    check("arst_req", {31'b0, IMEM_Req}, 32'd0);
    check("arst_pc", PC, 32'h0);
    check("arst_misalign", {31'b0, Misalign}, 32'd0);
    check("arst_instr", Instr, 32'h0);
    IMEM_Ack  = 1'b1;
    IMEM_Data = 32'hBAD0_BAD0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    IMEM_Ack  = 1'b0;
    IMEM_Data = 32'h0;
    check("late_ack_valid", {31'b0, Instr_Valid}, 32'd0);
    check("late_ack_instr", Instr, 32'h0);
    fetch_ack(0, 32'hD0D0_0001, 32'h0);

    tick();
    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifstage_hs.md
IFSTAGE_HS -- requirements
Module: ifstage_hs

Interface
REQ-001 Parameters (name, default, meaning):
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 15, maximum FETCH cycles without IMEM_Ack before Fetch_Err fires.

REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.

REQ-003 Ports (name, direction, width, meaning):
- Clk, in, 1, rising-edge clock.
- Reset, in, 1, asynchronous active-low reset; asserted when 0.
- PC_sel, in, 1, next-PC select: 0 = PC+4, 1 = PC+4+PC_Immed.
- PC_Immed, in, 32, branch offset, already sign-extended and shifted by decstage.
- PC_LdEn, in, 1, advance request from control; accepted only in VALID.
- IMEM_Req, out, 1, instruction memory request.
- IMEM_Addr, out, 32, word-aligned fetch address.
- IMEM_Ack, in, 1, memory response strobe; IMEM_Data is valid in the same cycle.
- IMEM_Data, in, 32, returned instruction word.
- Instr, out, 32, registered instruction that feeds decstage.
- Instr_Valid, out, 1, Instr holds the word at the current PC.
- PC, out, 32, current PC.
- Busy, out, 1, high in every state except VALID.
- Misalign, out, 1, sticky flag: a computed next PC had a nonzero [1:0].
- Fetch_Err, out, 1, one-cycle pulse on a timeout.

Function
REQ-004 The block SHALL implement three states, IDLE, FETCH and VALID, with these transitions:
- IDLE -> FETCH unconditionally.
- FETCH -> VALID on IMEM_Ack=1.
- VALID -> FETCH on PC_LdEn=1.

REQ-005 In FETCH, IMEM_Req SHALL be 1, combinationally in the state, and IMEM_Addr SHALL be {PC[31:2],2'b00}; in every other state IMEM_Req SHALL be 0 and IMEM_Addr SHALL still show the aligned PC.

REQ-006 On a FETCH cycle with IMEM_Ack=1, the block SHALL register Instr<=IMEM_Data and Instr_Valid<=1, so Instr is visible exactly one cycle after the ack.

REQ-007 IMEM_Ack outside FETCH SHALL be ignored, with no change to Instr, Instr_Valid or state.

REQ-008 In VALID with PC_LdEn=1, the block SHALL:
- load PC with the next address, computed as PC+4 (PC_sel=0) or PC+4+PC_Immed (PC_sel=1);
- clear Instr_Valid;
- enter FETCH on the next edge.

REQ-009 Next-PC arithmetic SHALL be 32-bit unsigned modulo 2^32 (0xFFFF_FFFC+4 wraps to 0x0000_0000).

REQ-010 If the computed next PC has [1:0] != 0, the block SHALL set Misalign (cleared only by reset) and load the PC with [1:0] forced to 00.

REQ-011 PC_LdEn in IDLE or FETCH SHALL be ignored; PC is unchanged and no request is queued.

REQ-012 Instr SHALL hold its last value while Instr_Valid=0; decstage qualifies Instr with Instr_Valid.

REQ-013 A wait counter SHALL count FETCH cycles with IMEM_Ack=0 and clear on entry to FETCH and on ack. When the count reaches TIMEOUT:
- Fetch_Err SHALL pulse for 1 cycle;
- the counter SHALL clear;
- IMEM_Req SHALL stay high, re-issuing the same address;
- the state SHALL remain FETCH.

REQ-014 If IMEM_Ack=1 arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win: Instr is captured and Fetch_Err is not pulsed.

REQ-015 The counter width SHALL be at least clog2(TIMEOUT+1) bits and SHALL never wrap past TIMEOUT.

REQ-016 Busy SHALL be 0 only in VALID.

Reset
REQ-017 While Reset=0, asynchronously and independent of Clk, the block SHALL force:
- state to IDLE;
- PC to RESET_PC;
- Instr to 32'h0;
- Instr_Valid, Misalign and Fetch_Err to 0;
- the wait counter to 0;
- IMEM_Req to 0, immediately.

REQ-018 Reset asserted mid-FETCH SHALL abandon the outstanding request; a late IMEM_Ack after reset release SHALL be ignored unless the block is in FETCH again.

REQ-019 After reset release, the first rising edge SHALL move IDLE -> FETCH, and IMEM_Req SHALL rise in that cycle.

Verification
REQ-020 Reset release with RESET_PC=0, memory acking after 2 cycles with 32'h1234_5678:
- IMEM_Req is high with IMEM_Addr=0;
- the cycle after the ack, Instr=32'h1234_5678 and Instr_Valid=1.

REQ-021 Sequential flow: in VALID with PC=0x10, PC_sel=0, PC_LdEn=1:
- the next cycle shows PC=0x14, Instr_Valid=0 and IMEM_Req=1 with IMEM_Addr=0x14.

REQ-022 Branch: PC=0x100, PC_sel=1, PC_Immed=32'hFFFF_FFF0 -> PC=0xF4.
- Wrap: PC=0xFFFF_FFFC, PC_sel=0 -> PC=0x0.

REQ-023 Timeout: no ack for 15 FETCH cycles:
- Fetch_Err pulses once and the request stays asserted;
- with ack on the 15th cycle instead, no pulse and Instr is captured.

REQ-024 Illegal and asynchronous inputs:
- PC_Immed=32'h2 -> Misalign=1 and PC low bits 00;
- PC_LdEn held during FETCH -> PC unchanged;
- Reset=0 mid-FETCH -> IMEM_Req drops without a clock edge and a later stray ack is ignored.
